// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t          : controller state encoding (IDLE/RUN/DONE)
//   SERIAL_ADD_W_DEF : default operand width
// -----------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADD_W_DEF = 8;

endpackage : serial_add_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder, the only arithmetic element of the serial adder.
// Ports:
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial W-bit adder: one full_adder reused for one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b                 : operands, sampled on accept
//   sub                  : (SERIAL_ADD_SUB_EN only) 1 = compute a - b
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum, cout            : result and final carry, held until next result
//   busy                 : high in RUN or DONE
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = SERIAL_ADD_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    // Counter width never below 1 bit; W-1 always fits, so no overflow for
    // power-of-two W.
    localparam int             CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sr_q, a_sr_d;
    logic [W-1:0]   b_sr_q, b_sr_d;
    logic [W-1:0]   res_q,  res_d;
    logic           carry_q, carry_d;
    logic           cout_q,  cout_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic           fa_s;
    logic           fa_co;
    logic [W-1:0]   b_load;
    logic           carry_init;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d       = a_sr_q >> 1;
                b_sr_d       = b_sr_q >> 1;
                // Sum bits enter at the MSB so bit 0 lands in res[0] after W shifts;
                // written as shift-then-set so W=1 needs no special case.
                res_d        = res_q >> 1;
                res_d[W-1]   = fa_s;
                carry_d      = fa_co;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = res_q;
    assign cout      = cout_q;

endmodule : serial_add_ctrl
